// File: rtl/iq_integrate_dump.sv
// iq_integrate_dump: integrate-and-dump decimator for the 2-bit I/Q mixer products.
// Sums DUMP_LEN accepted samples per channel and presents one signed sum pair per
// window on a valid/ready output. A finished window that finds the output slot
// still occupied parks in a pending register and upstream is stalled until the
// consumer drains the slot.
// Optional feature macro: IQ_OVF_SAT_EN -- when defined, the output conversion
// saturates and sat_flag records any clipping; when undefined, the conversion
// keeps the low OUT_W bits and sat_flag stays 0.
module iq_integrate_dump #(
   parameter int DUMP_LEN = 16,
   parameter int ACC_W    = 8,
   parameter int OUT_W    = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [1:0]       I_in,
   input  logic signed [1:0]       Q_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] I_out,
   output logic signed [OUT_W-1:0] Q_out,
   output logic                    sat_flag
);

   localparam int CNT_W = $clog2(DUMP_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_LEN - 1);

   typedef enum logic {ACC, STALL} state_t;

   state_t                    state_q,     state_d;
   logic [CNT_W-1:0]          cnt_q,       cnt_d;
   logic signed [ACC_W-1:0]   acc_i_q,     acc_i_d;
   logic signed [ACC_W-1:0]   acc_q_q,     acc_q_d;
   logic signed [ACC_W-1:0]   pend_i_q,    pend_i_d;
   logic signed [ACC_W-1:0]   pend_q_q,    pend_q_d;
   logic                      out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]   i_out_q,     i_out_d;
   logic signed [OUT_W-1:0]   q_out_q,     q_out_d;
   logic                      sat_q,       sat_d;

   logic signed [ACC_W-1:0]   ext_i, ext_q, sum_i, sum_q, src_i, src_q;
   logic [OUT_W:0]            conv_i, conv_q;
   logic                      slot_free;

   // Reduce an accumulator value to the output width; MSB of the result flags clipping.
   function automatic logic [OUT_W:0] conv(input logic signed [ACC_W-1:0] v);
`ifdef IQ_OVF_SAT_EN
      logic signed [ACC_W-1:0] sat_max;
      logic signed [ACC_W-1:0] sat_min;
      sat_max = ACC_W'((1 << (OUT_W - 1)) - 1);
      sat_min = ~sat_max;
      if (v > sat_max)
         conv = {1'b1, sat_max[OUT_W-1:0]};
      else if (v < sat_min)
         conv = {1'b1, sat_min[OUT_W-1:0]};
      else
         conv = {1'b0, v[OUT_W-1:0]};
`else
      conv = {1'b0, v[OUT_W-1:0]};
`endif
   endfunction

   // Sign-extend the mixer products and form the running sums; the converter is
   // shared between a fresh window sum (ACC) and the parked sum (STALL).
   always_comb begin
      ext_i     = {{(ACC_W-2){I_in[1]}}, I_in};
      ext_q     = {{(ACC_W-2){Q_in[1]}}, Q_in};
      sum_i     = acc_i_q + ext_i;
      sum_q     = acc_q_q + ext_q;
      src_i     = (state_q == STALL) ? pend_i_q : sum_i;
      src_q     = (state_q == STALL) ? pend_q_q : sum_q;
      conv_i    = conv(src_i);
      conv_q    = conv(src_q);
      slot_free = !out_valid_q || out_ready;
   end

   // Next-state logic: accumulate, dump into the output slot, or park and stall.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      pend_i_d    = pend_i_q;
      pend_q_d    = pend_q_q;
      out_valid_d = out_valid_q;
      i_out_d     = i_out_q;
      q_out_d     = q_out_q;
      sat_d       = sat_q;
      case (state_q)
         ACC: begin
            if (out_valid_q && out_ready)
               out_valid_d = 1'b0;
            if (in_valid) begin
               if (cnt_q != CNT_LAST) begin
                  acc_i_d = sum_i;
                  acc_q_d = sum_q;
                  cnt_d   = cnt_q + 1'b1;
               end else begin
                  acc_i_d = '0;
                  acc_q_d = '0;
                  cnt_d   = '0;
                  if (slot_free) begin
                     i_out_d     = conv_i[OUT_W-1:0];
                     q_out_d     = conv_q[OUT_W-1:0];
                     out_valid_d = 1'b1;
                     sat_d       = sat_q | conv_i[OUT_W] | conv_q[OUT_W];
                  end else begin
                     pend_i_d = sum_i;
                     pend_q_d = sum_q;
                     state_d  = STALL;
                  end
               end
            end
         end
         STALL: begin
            if (out_ready) begin
               i_out_d     = conv_i[OUT_W-1:0];
               q_out_d     = conv_q[OUT_W-1:0];
               out_valid_d = 1'b1;
               sat_d       = sat_q | conv_i[OUT_W] | conv_q[OUT_W];
               state_d     = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   // State register with synchronous active-low reset; reset drops any partial or parked sum.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ACC;
         cnt_q       <= '0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         pend_i_q    <= '0;
         pend_q_q    <= '0;
         out_valid_q <= 1'b0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         pend_i_q    <= pend_i_d;
         pend_q_q    <= pend_q_d;
         out_valid_q <= out_valid_d;
         i_out_q     <= i_out_d;
         q_out_q     <= q_out_d;
         sat_q       <= sat_d;
      end
   end

   // in_ready depends only on the registered state, never on out_ready.
   assign in_ready  = (state_q == ACC);
   assign out_valid = out_valid_q;
   assign I_out     = i_out_q;
   assign Q_out     = q_out_q;
   assign sat_flag  = sat_q;

endmodule
